// File: rtl/arb_pkg.sv
// Shared definitions for the 3-requester arbitration slice: requester count,
// source index type and the priority helpers used by grant qualification.
package arb_pkg;

  localparam int NUM_REQ = 3;

  typedef logic [1:0] src_id_t;

  function automatic logic [2:0] lowest_set(input logic [2:0] v);
    logic [2:0] r;
    if (v[0]) begin
      r = 3'b001;
    end else if (v[1]) begin
      r = 3'b010;
    end else if (v[2]) begin
      r = 3'b100;
    end else begin
      r = 3'b000;
    end
    return r;
  endfunction

  function automatic src_id_t onehot_idx(input logic [2:0] oh);
    src_id_t r;
    case (oh)
      3'b010:  r = 2'd1;
      3'b100:  r = 2'd2;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  function automatic logic multi_hot(input logic [2:0] v);
    return |(v & (v - 3'd1));
  endfunction

endpackage

// File: rtl/req_sync_fifo.sv
// Single-clock FIFO with a combinational head; push is refused when full and
// pop is refused when empty, so callers may drive raw requests.
module req_sync_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign rdata     = mem_r[rd_ptr_r];

  // storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/req_fifo_bank.sv
// Per-requester FIFOs feeding a round-robin arbiter; the granted head is moved
// into a registered valid/ready output tagged with its source index.
module req_fifo_bank
  import arb_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    in_valid,
  input  logic [NUM_REQ*DW-1:0] in_data,
  output logic [NUM_REQ-1:0]    in_ready,
  output logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    grant,
  output logic                  out_valid,
  output logic [DW-1:0]         out_data,
  output logic [1:0]            out_src,
  input  logic                  out_ready,
  output logic                  err_grant
);

  logic [NUM_REQ-1:0] full_s;
  logic [NUM_REQ-1:0] empty_s;
  logic [NUM_REQ-1:0] qgrant_s;
  logic [NUM_REQ-1:0] pop_s;
  logic [DW-1:0]      head_s [NUM_REQ];
  logic [DW-1:0]      pop_data_s;
  src_id_t            pop_idx_s;
  logic               slot_free_s;
  logic               out_valid_r;
  logic [DW-1:0]      out_data_r;
  src_id_t            out_src_r;
  logic               err_grant_r;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
    req_sync_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid[g]),
      .pop   (pop_s[g]),
      .wdata (in_data[DW*g +: DW]),
      .rdata (head_s[g]),
      .full  (full_s[g]),
      .empty (empty_s[g])
    );
  end

  // requests are withheld while the output slot cannot take a beat
  assign slot_free_s = ~out_valid_r | out_ready;
  assign req         = ~empty_s & {NUM_REQ{slot_free_s}};
  assign in_ready    = ~full_s;
  assign qgrant_s    = grant & req;
  assign pop_s       = lowest_set(qgrant_s);
  assign pop_idx_s   = onehot_idx(pop_s);

  // head of the FIFO being popped
  always_comb begin
    pop_data_s = {DW{1'b0}};
    case (pop_idx_s)
      2'd0:    pop_data_s = head_s[0];
      2'd1:    pop_data_s = head_s[1];
      2'd2:    pop_data_s = head_s[2];
      default: pop_data_s = {DW{1'b0}};
    endcase
  end

  // output register: load on pop, drop valid on accept, otherwise hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DW{1'b0}};
      out_src_r   <= 2'd0;
    end else if (|pop_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= pop_data_s;
      out_src_r   <= pop_idx_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // sticky flag; a multi-hot qualified grant is a subset of a multi-hot grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_grant_r <= 1'b0;
    end else if (multi_hot(grant) | multi_hot(qgrant_s)) begin
      err_grant_r <= 1'b1;
    end else begin
      err_grant_r <= err_grant_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_src   = out_src_r;
  assign err_grant = err_grant_r;

endmodule

// File: tb/tb_req_fifo_bank.sv
// Scoreboard bench: a queue-based model predicts every popped beat and a
// separate monitor checks each accepted output beat against it.
module tb_req_fifo_bank;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  in_valid = 3'b000;
  logic [23:0] in_data = 24'h0;
  logic [2:0]  in_ready;
  logic [2:0]  req;
  logic [2:0]  grant = 3'b000;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_src;
  logic        out_ready = 1'b0;
  logic        err_grant;

  always #5 clk = ~clk;

  req_fifo_bank #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .req       (req),
    .grant     (grant),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .err_grant (err_grant)
  );

  typedef logic [7:0] byte_q_t [$];
  typedef struct packed {
    logic [1:0] src;
    logic [7:0] data;
  } beat_t;

  byte_q_t    mq [3];
  beat_t      sb [$];
  logic       m_ov = 1'b0;
  logic [7:0] m_od = 8'h00;
  logic [1:0] m_os = 2'd0;
  logic       m_err = 1'b0;
  int         rr_last = 2;
  logic [2:0] last_gnt = 3'b000;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) mq[i].delete();
    sb.delete();
    m_ov = 1'b0; m_od = 8'h00; m_os = 2'd0; m_err = 1'b0;
    rr_last = 2; last_gnt = 3'b000;
  endtask

  // One clock cycle: drive inputs, check DUT against model, advance model.
  task automatic cycle(input logic [2:0] iv, input logic [23:0] id,
                       input logic [2:0] gnt_in, input logic ordy, input bit use_arb);
    logic [2:0] mreq, mfull, g, qg;
    logic       sf;
    logic [7:0] d;
    int         p;
    sf = !m_ov || ordy;
    for (int i = 0; i < 3; i++) begin
      mfull[i] = (mq[i].size() == DEPTH);
      mreq[i]  = (mq[i].size() != 0) && sf;
    end
    g = gnt_in;
    if (use_arb) begin
      if (mreq == 3'b000) begin
        g = last_gnt;
      end else begin
        for (int k = 1; k <= 3; k++) begin
          if (mreq[(rr_last + k) % 3] && g == gnt_in) begin
            rr_last  = (rr_last + k) % 3;
            g        = 3'(1 << rr_last);
            last_gnt = g;
          end
        end
      end
    end
    in_valid = iv; in_data = id; grant = g; out_ready = ordy;
    #1;
    chk("req", {29'd0, req}, {29'd0, mreq});
    chk("in_ready", {29'd0, in_ready}, {29'd0, ~mfull});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    chk("out_data", {24'd0, out_data}, {24'd0, m_od});
    chk("out_src", {30'd0, out_src}, {30'd0, m_os});
    chk("err_grant", {31'd0, err_grant}, {31'd0, m_err});
    qg = g & mreq;
    p = -1;
    for (int i = 0; i < 3; i++) if (qg[i] && p < 0) p = i;
    if ($countones(g) > 1) m_err = 1'b1;
    if (p >= 0) begin
      d = mq[p].pop_front();
      sb.push_back({2'(p), d});
      m_ov = 1'b1; m_od = d; m_os = 2'(p);
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    for (int i = 0; i < 3; i++) if (iv[i] && !mfull[i]) mq[i].push_back(id[8*i +: 8]);
    @(posedge clk); #1;
  endtask

  task automatic drain_all();
    int n;
    n = 0;
    while ((m_ov || mq[0].size() != 0 || mq[1].size() != 0 || mq[2].size() != 0) && n < 100) begin
      cycle(3'b000, 24'h0, 3'b000, 1'b1, 1'b1);
      n++;
    end
    if (n >= 100) begin
      errors++; checks++;
      $display("FAIL drain_timeout actual=%0d expected<100", n);
    end
  endtask

  // Monitor: every handshake must match the oldest predicted beat.
  always @(negedge clk) begin
    beat_t e;
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat actual src=%0d data=%0h expected none", out_src, out_data);
      end else begin
        e = sb.pop_front();
        chk("beat_src", {30'd0, out_src}, {30'd0, e.src});
        chk("beat_data", {24'd0, out_data}, {24'd0, e.data});
      end
    end
  end

  initial begin
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_req", {29'd0, req}, 32'd0);
    chk("rst_in_ready", {29'd0, in_ready}, 32'd7);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // single beat on requester 1
    cycle(3'b010, 24'h00A500, 3'b000, 1'b1, 1'b1);
    cycle(3'b000, 24'h0, 3'b000, 1'b1, 1'b1);
    cycle(3'b000, 24'h0, 3'b000, 1'b1, 1'b1);
    drain_all();

    // fill all three, then drain round-robin; first drain cycle also tries a push while full
    rr_last = 2;
    for (int k = 0; k < 4; k++)
      cycle(3'b111, {8'(8'h20 + k), 8'(8'h10 + k), 8'(8'h00 + k)}, 3'b000, 1'b1, 1'b0);
    cycle(3'b111, 24'hFFFFFF, 3'b000, 1'b1, 1'b1);
    for (int k = 0; k < 13; k++) cycle(3'b000, 24'h0, 3'b000, 1'b1, 1'b1);
    drain_all();

    // asynchronous reset with FIFOs partly filled and out_valid set
    cycle(3'b111, 24'h312111, 3'b000, 1'b1, 1'b0);
    cycle(3'b111, 24'h322212, 3'b000, 1'b1, 1'b1);
    cycle(3'b000, 24'h0, 3'b000, 1'b0, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_req", {29'd0, req}, 32'd0);
    chk("mid_rst_in_ready", {29'd0, in_ready}, 32'd7);
    chk("mid_rst_err", {31'd0, err_grant}, 32'd0);
    model_clear();
    in_valid = 3'b000; grant = 3'b000;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // backpressure for 5 cycles, then release
    cycle(3'b111, 24'h524232, 3'b000, 1'b1, 1'b0);
    cycle(3'b111, 24'h534333, 3'b000, 1'b1, 1'b0);
    cycle(3'b000, 24'h0, 3'b000, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) cycle(3'b000, 24'h0, 3'b000, 1'b0, 1'b1);
    drain_all();

    // grant to an empty FIFO, then a two-hot qualified grant
    cycle(3'b010, 24'h006100, 3'b000, 1'b1, 1'b0);
    cycle(3'b000, 24'h0, 3'b001, 1'b1, 1'b0);
    cycle(3'b001, 24'h000070, 3'b000, 1'b1, 1'b0);
    cycle(3'b000, 24'h0, 3'b011, 1'b1, 1'b0);
    cycle(3'b000, 24'h0, 3'b000, 1'b1, 1'b0);
    drain_all();

    // concurrent push/pop on FIFO 2 at count 2, then a push at full is dropped
    cycle(3'b100, 24'hC00000, 3'b000, 1'b1, 1'b0);
    cycle(3'b100, 24'hC10000, 3'b000, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) cycle(3'b100, {8'(8'hC2 + k), 16'h0}, 3'b100, 1'b1, 1'b0);
    cycle(3'b100, 24'hD70000, 3'b000, 1'b1, 1'b0);
    cycle(3'b100, 24'hD80000, 3'b000, 1'b1, 1'b0);
    cycle(3'b100, 24'hD90000, 3'b000, 1'b1, 1'b0);
    drain_all();

    // randomized traffic, mostly round-robin grants with occasional raw grants
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0)
        cycle(3'($urandom_range(0, 7)), 24'($urandom), 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 3) != 0), 1'b0);
      else
        cycle(3'($urandom_range(0, 7)), 24'($urandom), 3'b000,
              1'($urandom_range(0, 3) != 0), 1'b1);
    end
    drain_all();
    chk("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
